// File: rtl/fp_add_scheduler_pkg.sv
// Shared FSM state type, FP32 field constants and
// NaN/Inf classification for the FP adder scheduler.
package fp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } schedState_t;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  function automatic logic is_nan(logic [31:0] x);
    return (x[MAN_W +: EXP_W] == EXP_MAX) &&
           (x[MAN_W-1:0] != '0);
  endfunction

  function automatic logic is_inf(logic [31:0] x);
    return (x[MAN_W +: EXP_W] == EXP_MAX) &&
           (x[MAN_W-1:0] == '0);
  endfunction

endpackage

// File: rtl/fp_add_scheduler_if.sv
// Request, adder and response signals of the scheduler.
// slave = scheduler side, master = clients/adder side.
interface fp_add_scheduler_if #(
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ-1:0]    req_ready;
  logic               add_start;
  logic [31:0]        add_a;
  logic [31:0]        add_b;
  logic               add_done;
  logic [31:0]        add_result;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_result;
  logic               rsp_error;
  logic               rsp_nan;
  logic               rsp_inf;
  logic               busy;

  modport slave (
    input  req_valid, req_a, req_b,
    input  add_done, add_result, rsp_ready,
    output req_ready, add_start, add_a, add_b,
    output rsp_valid, rsp_id, rsp_result,
    output rsp_error, rsp_nan, rsp_inf, busy
  );

  modport master (
    output req_valid, req_a, req_b,
    output add_done, add_result, rsp_ready,
    input  req_ready, add_start, add_a, add_b,
    input  rsp_valid, rsp_id, rsp_result,
    input  rsp_error, rsp_nan, rsp_inf, busy
  );

endinterface

// File: rtl/fp_add_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first request
// after ptr, wrapping; ptr register lives in the caller.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] id
);

  always_comb begin
    int idx;
    logic found;
    grant = '0;
    id    = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        id         = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/fp_add_scheduler.sv
// Shares one FP32 adder between NREQ clients: RR grant,
// issue, bounded wait, tagged response.
module fp_add_scheduler
  import fp_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 15
) (
  input logic clk,
  input logic rst_n,
  fp_add_scheduler_if.slave bus
);

  localparam int IDW = $clog2(NREQ);

  schedState_t state;
  schedState_t stateNext;

  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  gntId;
  logic [IDW-1:0]  gntNext;
  logic [NREQ-1:0] grant;
  logic [31:0]     opA;
  logic [31:0]     opB;
  logic [31:0]     result;
  logic            rspErr;
  logic [7:0]      cnt;
  logic [7:0]      cntInc;
  logic            timeoutHit;
  logic            arbEn;

  // gated by rst_n so req_ready is 0 while reset is held
  assign arbEn = (state == IDLE) && rst_n;

  rr_arbiter #(
    .N   (NREQ),
    .IDW (IDW)
  ) uArb (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .en    (arbEn),
    .grant (grant),
    .id    (gntNext)
  );

  assign cntInc     = cnt + 8'd1;
  assign timeoutHit = (cntInc == 8'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext     = state;
    bus.req_ready = '0;
    bus.add_start = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.busy      = (state != IDLE);
    unique case (state)
      IDLE: begin
        bus.req_ready = grant;
        if (|grant) stateNext = ISSUE;
      end
      ISSUE: begin
        bus.add_start = 1'b1;
        stateNext     = WAIT;
      end
      WAIT: begin
        if (bus.add_done || timeoutHit)
          stateNext = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= IDW'(NREQ - 1);
      gntId  <= '0;
      opA    <= '0;
      opB    <= '0;
      cnt    <= '0;
      result <= '0;
      rspErr <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|grant) begin
            opA   <= bus.req_a[32*int'(gntNext) +: 32];
            opB   <= bus.req_b[32*int'(gntNext) +: 32];
            gntId <= gntNext;
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          cnt <= cntInc;
          // completion beats a coincident timeout
          if (bus.add_done) begin
            result <= bus.add_result;
            rspErr <= 1'b0;
          end else if (timeoutHit) begin
            result <= QNAN;
            rspErr <= 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) ptr <= gntId;
        end
        default: ;
      endcase
    end
  end

  assign bus.add_a      = opA;
  assign bus.add_b      = opB;
  assign bus.rsp_id     = gntId;
  assign bus.rsp_result = result;
  assign bus.rsp_error  = rspErr;
  assign bus.rsp_nan    = is_nan(result);
  assign bus.rsp_inf    = is_inf(result);

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Bench for fp_add_scheduler: adder stand-in, monitors
// and a round-robin reference model.
module tb_fp_add_scheduler;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 15;
  localparam int IDW     = $clog2(NREQ);

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        err;
    logic        nan;
    logic        inf;
    int          cyc;
  } rsp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  int          addDelay = 1;
  bit          forceEn  = 1'b0;
  logic [31:0] forceVal = '0;
  logic [31:0] mdlRes;
  logic [31:0] opsA [NREQ];
  logic [31:0] opsB [NREQ];

  int          grantQ[$];
  int          grantCycQ[$];
  int          startCycQ[$];
  logic [31:0] startAQ[$];
  logic [31:0] startBQ[$];
  int          validCycQ[$];
  rsp_t        rspQ[$];
  logic        prevValid;

  fp_add_scheduler_if #(.NREQ(NREQ)) ifc ();

  fp_add_scheduler #(
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  logic [NREQ+IDW+102-1:0] allOut;
  assign allOut = {ifc.req_ready, ifc.add_start,
                   ifc.add_a, ifc.add_b, ifc.rsp_valid,
                   ifc.rsp_id, ifc.rsp_result,
                   ifc.rsp_error, ifc.rsp_nan,
                   ifc.rsp_inf, ifc.busy};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] addModel(
    logic [31:0] a, logic [31:0] b);
    return a + b;
  endfunction

  function automatic int rrPick(int last,
                                logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  function automatic logic expNan(logic [31:0] r);
    return (r[30:23] == 8'hFF) && (r[22:0] != 23'd0);
  endfunction

  function automatic logic expInf(logic [31:0] r);
    return (r[30:23] == 8'hFF) && (r[22:0] == 23'd0);
  endfunction

  function automatic int onehotIdx(logic [NREQ-1:0] v);
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // adder stand-in: done pulse addDelay cycles after start
  initial begin
    ifc.add_done   = 1'b0;
    ifc.add_result = '0;
    forever begin
      @(negedge clk);
      if (rst_n && ifc.add_start === 1'b1 && addDelay > 0) begin
        mdlRes = forceEn ? forceVal
                         : addModel(ifc.add_a, ifc.add_b);
        repeat (addDelay) @(posedge clk);
        #1;
        ifc.add_done   = 1'b1;
        ifc.add_result = mdlRes;
        @(posedge clk);
        #1;
        ifc.add_done   = 1'b0;
        ifc.add_result = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      grantQ.delete();
      grantCycQ.delete();
      startCycQ.delete();
      startAQ.delete();
      startBQ.delete();
      validCycQ.delete();
      rspQ.delete();
    end else begin
      if (ifc.req_ready != '0) begin
        grantQ.push_back(onehotIdx(ifc.req_ready));
        grantCycQ.push_back(cyc);
      end
      if (ifc.add_start === 1'b1) begin
        startCycQ.push_back(cyc);
        startAQ.push_back(ifc.add_a);
        startBQ.push_back(ifc.add_b);
      end
      if (ifc.rsp_valid && !prevValid)
        validCycQ.push_back(cyc);
      if (ifc.rsp_valid && ifc.rsp_ready)
        rspQ.push_back('{int'(ifc.rsp_id), ifc.rsp_result,
                         ifc.rsp_error, ifc.rsp_nan,
                         ifc.rsp_inf, cyc});
    end
    prevValid = rst_n && ifc.rsp_valid;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run did not end");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    ifc.req_valid = '0;
    ifc.req_a     = '0;
    ifc.req_b     = '0;
    ifc.rsp_ready = 1'b0;
    forceEn       = 1'b0;
    addDelay      = 1;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic load_ops();
    for (int i = 0; i < NREQ; i++) begin
      opsA[i] = $urandom() | 32'h1;
      opsB[i] = $urandom();
      ifc.req_a[32*i +: 32] = opsA[i];
      ifc.req_b[32*i +: 32] = opsB[i];
    end
  endtask

  task automatic test_reset();
    ifc.req_valid = '1;
    ifc.rsp_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (allOut !== '0) begin
      errors++;
      $display("FAIL reset_hold outputs got %h want 0",
               allOut);
    end
    do_reset();
    tick();
    checks++;
    if (allOut !== '0) begin
      errors++;
      $display("FAIL reset_release outputs got %h want 0",
               allOut);
    end
  endtask

  task automatic test_single();
    int n;
    do_reset();
    forceEn  = 1'b1;
    forceVal = 32'h4040_0000;
    addDelay = 1;
    ifc.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    ifc.req_a[31:0] = 32'h3F80_0000;
    ifc.req_b[31:0] = 32'h4000_0000;
    ifc.req_valid   = NREQ'(1);
    n = 0;
    while (grantQ.size() < 1 && n < 10) begin
      tick();
      n++;
    end
    @(posedge clk);
    #1 ifc.req_valid = '0;
    n = 0;
    while (rspQ.size() < 1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (rspQ.size() != 1 || grantQ.size() != 1) begin
      errors++;
      $display("FAIL single_count rsp %0d grant %0d want 1 1",
               rspQ.size(), grantQ.size());
    end
    if (rspQ.size() >= 1 && startCycQ.size() >= 1) begin
      checks++;
      if (grantQ[0] != 0) begin
        errors++;
        $display("FAIL single_grant got %0d want 0",
                 grantQ[0]);
      end
      checks++;
      if (startCycQ[0] != grantCycQ[0] + 1) begin
        errors++;
        $display("FAIL single_start_lat got %0d want %0d",
                 startCycQ[0], grantCycQ[0] + 1);
      end
      checks++;
      if (validCycQ[0] != grantCycQ[0] + 3) begin
        errors++;
        $display("FAIL single_rsp_lat got %0d want %0d",
                 validCycQ[0], grantCycQ[0] + 3);
      end
      checks++;
      if (startAQ[0] !== 32'h3F80_0000 ||
          startBQ[0] !== 32'h4000_0000) begin
        errors++;
        $display("FAIL single_ops got %h %h want 3f800000 40000000",
                 startAQ[0], startBQ[0]);
      end
      checks++;
      if (rspQ[0].id != 0 || rspQ[0].res !== 32'h4040_0000 ||
          rspQ[0].err !== 1'b0) begin
        errors++;
        $display("FAIL single_rsp got id %0d res %h err %b want 0 40400000 0",
                 rspQ[0].id, rspQ[0].res, rspQ[0].err);
      end
    end
    forceEn = 1'b0;
  endtask

  task automatic test_round_robin();
    int n;
    int expOrder[5];
    expOrder = '{0, 1, 2, 3, 0};
    do_reset();
    addDelay = int'($urandom_range(1, 4));
    ifc.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    load_ops();
    ifc.req_valid = '1;
    n = 0;
    while (rspQ.size() < 5 && n < 80) begin
      tick();
      n++;
    end
    @(posedge clk);
    #1 ifc.req_valid = '0;
    checks++;
    if (rspQ.size() < 5) begin
      errors++;
      $display("FAIL rr_count got %0d want 5", rspQ.size());
    end
    for (int i = 0; i < 5 && i < rspQ.size(); i++) begin
      checks++;
      if (grantQ[i] != expOrder[i] || rspQ[i].id != grantQ[i] ||
          rspQ[i].res !== addModel(opsA[expOrder[i]],
                                   opsB[expOrder[i]])) begin
        errors++;
        $display("FAIL rr_op%0d grant %0d id %0d res %h want %0d %h",
                 i, grantQ[i], rspQ[i].id, rspQ[i].res,
                 expOrder[i],
                 addModel(opsA[expOrder[i]], opsB[expOrder[i]]));
      end
      if (i < 4 && grantCycQ.size() > i + 1) begin
        checks++;
        if (grantCycQ[i+1] != rspQ[i].cyc + 1) begin
          errors++;
          $display("FAIL rr_b2b%0d grant cyc %0d want %0d",
                   i, grantCycQ[i+1], rspQ[i].cyc + 1);
        end
      end
    end
    n = 0;
    while (ifc.busy && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (ifc.busy !== 1'b0) begin
      errors++;
      $display("FAIL rr_idle busy got %b want 0", ifc.busy);
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    addDelay = -1;
    ifc.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    load_ops();
    ifc.req_valid = NREQ'(2);
    tick();
    @(posedge clk);
    #1 ifc.req_valid = '0;
    n = 0;
    while (rspQ.size() < 1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (rspQ.size() != 1) begin
      errors++;
      $display("FAIL timeout_count got %0d want 1", rspQ.size());
    end else begin
      checks++;
      if (validCycQ[0] - startCycQ[0] != TIMEOUT + 1) begin
        errors++;
        $display("FAIL timeout_lat got %0d want %0d",
                 validCycQ[0] - startCycQ[0], TIMEOUT + 1);
      end
      checks++;
      if (rspQ[0].id != 1 || rspQ[0].res !== 32'h7FC0_0000 ||
          rspQ[0].err !== 1'b1 || rspQ[0].nan !== 1'b1 ||
          rspQ[0].inf !== 1'b0) begin
        errors++;
        $display("FAIL timeout_rsp id %0d res %h e%b n%b i%b want 1 7fc00000 1 1 0",
                 rspQ[0].id, rspQ[0].res, rspQ[0].err,
                 rspQ[0].nan, rspQ[0].inf);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [IDW+34:0] snap;
    do_reset();
    addDelay = 2;
    ifc.rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    load_ops();
    ifc.req_valid = '1;
    n = 0;
    while (!ifc.rsp_valid && n < 20) begin
      tick();
      n++;
    end
    snap = {ifc.rsp_id, ifc.rsp_result, ifc.rsp_error,
            ifc.rsp_nan, ifc.rsp_inf};
    checks++;
    if (ifc.rsp_valid !== 1'b1 || ifc.rsp_id !== IDW'(0) ||
        ifc.rsp_result !== addModel(opsA[0], opsB[0])) begin
      errors++;
      $display("FAIL bp_first v%b id %0d res %h want 1 0 %h",
               ifc.rsp_valid, ifc.rsp_id, ifc.rsp_result,
               addModel(opsA[0], opsB[0]));
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({ifc.rsp_id, ifc.rsp_result, ifc.rsp_error,
           ifc.rsp_nan, ifc.rsp_inf} !== snap ||
          ifc.rsp_valid !== 1'b1 || ifc.req_ready !== '0 ||
          startCycQ.size() != 1) begin
        errors++;
        $display("FAIL bp_hold%0d v%b rdy %b starts %0d want 1 0 1",
                 i, ifc.rsp_valid, ifc.req_ready,
                 startCycQ.size());
      end
    end
    @(posedge clk);
    #1 ifc.rsp_ready = 1'b1;
    n = 0;
    while (grantQ.size() < 2 && n < 6) begin
      tick();
      n++;
    end
    checks++;
    if (grantQ.size() < 2 || rspQ.size() < 1) begin
      errors++;
      $display("FAIL bp_next grants %0d rsps %0d want 2 1",
               grantQ.size(), rspQ.size());
    end else if (grantQ[1] != 1 ||
                 grantCycQ[1] != rspQ[0].cyc + 1) begin
      errors++;
      $display("FAIL bp_next grant %0d cyc %0d want 1 %0d",
               grantQ[1], grantCycQ[1], rspQ[0].cyc + 1);
    end
    @(posedge clk);
    #1 ifc.req_valid = '0;
    n = 0;
    while (ifc.busy && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (ifc.busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_idle busy got %b want 0", ifc.busy);
    end
  endtask

  task automatic test_done_at_timeout();
    int n;
    do_reset();
    addDelay = TIMEOUT;
    forceEn  = 1'b1;
    forceVal = 32'h7F80_0000;
    ifc.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    load_ops();
    ifc.req_valid = NREQ'(4);
    tick();
    @(posedge clk);
    #1 ifc.req_valid = '0;
    n = 0;
    while (rspQ.size() < 1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (rspQ.size() != 1) begin
      errors++;
      $display("FAIL tie_count got %0d want 1", rspQ.size());
    end else begin
      checks++;
      if (validCycQ[0] - startCycQ[0] != TIMEOUT + 1) begin
        errors++;
        $display("FAIL tie_lat got %0d want %0d",
                 validCycQ[0] - startCycQ[0], TIMEOUT + 1);
      end
      checks++;
      if (rspQ[0].id != 2 || rspQ[0].res !== 32'h7F80_0000 ||
          rspQ[0].err !== 1'b0 || rspQ[0].inf !== 1'b1 ||
          rspQ[0].nan !== 1'b0) begin
        errors++;
        $display("FAIL tie_rsp id %0d res %h e%b i%b n%b want 2 7f800000 0 1 0",
                 rspQ[0].id, rspQ[0].res, rspQ[0].err,
                 rspQ[0].inf, rspQ[0].nan);
      end
    end
    forceEn = 1'b0;
  endtask

  task automatic test_async_reset();
    int n;
    do_reset();
    addDelay = -1;
    ifc.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    load_ops();
    ifc.req_valid = NREQ'(1);
    n = 0;
    while (startCycQ.size() < 1 && n < 10) begin
      tick();
      n++;
    end
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (allOut !== '0) begin
      errors++;
      $display("FAIL async_reset outputs got %h want 0",
               allOut);
    end
    addDelay = 1;
    ifc.req_valid = '1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    n = 0;
    while (rspQ.size() < 1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (rspQ.size() < 1 || grantQ.size() < 1) begin
      errors++;
      $display("FAIL async_restart rsps %0d grants %0d want 1 1",
               rspQ.size(), grantQ.size());
    end else if (grantQ[0] != 0 || rspQ[0].id != 0 ||
                 rspQ[0].err !== 1'b0 ||
                 rspQ[0].res !== addModel(opsA[0], opsB[0])) begin
      errors++;
      $display("FAIL async_restart grant %0d id %0d err %b res %h want 0 0 0 %h",
               grantQ[0], rspQ[0].id, rspQ[0].err, rspQ[0].res,
               addModel(opsA[0], opsB[0]));
    end
    @(posedge clk);
    #1 ifc.req_valid = '0;
    n = 0;
    while (ifc.busy && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_random();
    int n;
    int d;
    int expId;
    int last;
    int got;
    int pool[9];
    logic [NREQ-1:0] pat;
    logic [31:0] expRes;
    logic expErr;
    pool = '{1, 2, 3, 4, 5, 14, 15, 16, -1};
    do_reset();
    last = NREQ - 1;
    for (int op = 0; op < 24; op++) begin
      pat = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      d = pool[$urandom_range(0, 8)];
      expId = rrPick(last, pat);
      @(posedge clk);
      #1;
      addDelay = d;
      load_ops();
      ifc.req_valid = pat;
      tick();
      got = (grantQ.size() > op) ? grantQ[op] : -1;
      checks++;
      if (got != expId) begin
        errors++;
        $display("FAIL rnd_grant%0d pat %b got %0d want %0d",
                 op, pat, got, expId);
      end
      @(posedge clk);
      #1 ifc.req_valid = '0;
      n = 0;
      while (rspQ.size() < op + 1 && n < 60) begin
        @(posedge clk);
        #1 ifc.rsp_ready = ($urandom_range(0, 3) != 0);
        tick();
        n++;
      end
      expErr = (d < 0 || d > TIMEOUT);
      expRes = expErr ? 32'h7FC0_0000
                      : addModel(opsA[expId], opsB[expId]);
      checks++;
      if (rspQ.size() != op + 1) begin
        errors++;
        $display("FAIL rnd_rsp%0d count got %0d want %0d",
                 op, rspQ.size(), op + 1);
        break;
      end else if (rspQ[op].id != expId ||
                   rspQ[op].res !== expRes ||
                   rspQ[op].err !== expErr ||
                   rspQ[op].nan !== expNan(expRes) ||
                   rspQ[op].inf !== expInf(expRes)) begin
        errors++;
        $display("FAIL rnd_rsp%0d d %0d id %0d res %h e%b n%b i%b want %0d %h %b %b %b",
                 op, d, rspQ[op].id, rspQ[op].res,
                 rspQ[op].err, rspQ[op].nan, rspQ[op].inf,
                 expId, expRes, expErr, expNan(expRes),
                 expInf(expRes));
      end
      last = expId;
    end
  endtask

  initial begin
    ifc.req_valid = '0;
    ifc.req_a     = '0;
    ifc.req_b     = '0;
    ifc.rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_backpressure();
    test_done_at_timeout();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
